// File: rtl/digit_tick_counter.sv
// digit_tick_counter: debounced run/pause button, clock prescaler and a
// wrapping up/down BCD digit counter feeding the seven-segment decoder.
module digit_tick_counter #(
    parameter int PRESCALE  = 50000000,
    parameter int DEBOUNCE  = 1000000,
    parameter int DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       up_dn,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       digit_stb,
    output logic       carry,
    output logic       running
);

    localparam int PCNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int DCNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE - 1);
    localparam logic [3:0]        DMAX      = 4'(DIGIT_MAX);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    logic              btn_m;
    logic              btn_s;
    deb_state_t        state;
    deb_state_t        state_nx;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nx;
    logic              press;
    logic              press_nx;
    logic [PCNT_W-1:0] pcnt;
    logic              tick;

    // Two-flop synchronizer for the asynchronous pushbutton
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn_run;
            btn_s <= btn_m;
        end
    end

    // Debounce state register, hold counter and registered press pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RELEASED;
            dcnt  <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
            press <= press_nx;
        end
    end

    // Debounce next-state: a level must hold DEBOUNCE cycles to be accepted
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        case (state)
            RELEASED: begin
                if (btn_s) begin
                    state_nx = PRESS_WAIT;
                    dcnt_nx  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = RELEASED;
                end else if (dcnt == DCNT_LAST) begin
                    state_nx = PRESSED;
                end else begin
                    dcnt_nx = dcnt + DCNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                    dcnt_nx  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nx = PRESSED;
                end else if (dcnt == DCNT_LAST) begin
                    state_nx = RELEASED;
                end else begin
                    dcnt_nx = dcnt + DCNT_W'(1);
                end
            end
            default: begin
                state_nx = RELEASED;
                dcnt_nx  = '0;
            end
        endcase
    end

    // Debounce output: press pulse only on an accepted press, never on release
    always_comb begin
        press_nx = (state == PRESS_WAIT) && btn_s && (dcnt == DCNT_LAST);
    end

    // Run/pause toggles one edge after the registered press pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b1;
        end else if (press) begin
            running <= ~running;
        end
    end

    // Step tick fires in the last prescale cycle while running
    always_comb begin
        tick = running && (pcnt == PCNT_LAST);
    end

    // Prescaler: holds its count while paused so resume continues mid-period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (running) begin
            pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
        end
    end

    // Digit counter: clear beats tick; strobe/carry are single-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit     <= '0;
            digit_stb <= 1'b0;
            carry     <= 1'b0;
        end else begin
            digit_stb <= 1'b0;
            carry     <= 1'b0;
            if (clr) begin
                digit     <= '0;
                digit_stb <= (digit != 4'd0);
            end else if (tick) begin
                digit_stb <= 1'b1;
                if (up_dn) begin
                    if (digit == DMAX) begin
                        digit <= '0;
                        carry <= 1'b1;
                    end else begin
                        digit <= digit + 4'd1;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        digit <= DMAX;
                        carry <= 1'b1;
                    end else begin
                        digit <= digit - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_tick_counter.sv
// Scoreboard bench for digit_tick_counter: stimulus queues the expected
// (cycle, digit, carry) of every strobe; a negedge monitor pops and compares.
module tb_digit_tick_counter;

    logic       clk;
    logic       rst;
    logic       btn_run;
    logic       up_dn;
    logic       clr;
    logic [3:0] digit;
    logic       digit_stb;
    logic       carry;
    logic       running;

    typedef struct {
        int cyc;
        int d;
        int c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   base   = 0;
    int   checks = 0;
    int   errors = 0;

    digit_tick_counter #(
        .PRESCALE (4),
        .DEBOUNCE (3),
        .DIGIT_MAX(9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .up_dn    (up_dn),
        .clr      (clr),
        .digit    (digit),
        .digit_stb(digit_stb),
        .carry    (carry),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute edge count; after posedge N settles, cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic expect_stb(input int off, input int d, input int c);
        exp_t e;
        e.cyc = base + off;
        e.d   = d;
        e.c   = c;
        sb.push_back(e);
    endtask

    // Advance to just after edge base+t
    task automatic wait_to(input int t);
        while (cyc < base + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d strobes still pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Hold reset two edges, check reset values, release just after an edge
    task automatic reset_release(input string name);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk({name, "_rst_digit"}, int'(digit), 0);
        chk({name, "_rst_stb"}, int'(digit_stb), 0);
        chk({name, "_rst_carry"}, int'(carry), 0);
        chk({name, "_rst_running"}, int'(running), 1);
        rst  = 1'b1;
        base = cyc;
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("carry_without_stb", int'(carry & ~digit_stb), 0);
            if (digit_stb) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_stb: got strobe at cycle %0d digit %0d, expected none",
                             cyc, digit);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc != mon_e.cyc || int'(digit) != mon_e.d || int'(carry) != mon_e.c) begin
                        errors++;
                        $display("FAIL stb_event: got cycle %0d digit %0d carry %0d, expected cycle %0d digit %0d carry %0d",
                                 cyc, digit, carry, mon_e.cyc, mon_e.d, mon_e.c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        btn_run = 1'b0;
        up_dn   = 1'b1;
        clr     = 1'b0;

        // 1: count up, strobe every 4 cycles, carry only on 9->0
        reset_release("t1");
        for (int k = 1; k <= 10; k++) begin
            expect_stb(4 * k, k % 10, (k == 10) ? 1 : 0);
        end
        drain("t1_drain");

        // 2: count down from reset wraps 0->9 with carry
        rst   = 1'b0;
        up_dn = 1'b0;
        reset_release("t2");
        expect_stb(4, 9, 1);
        expect_stb(8, 8, 0);
        expect_stb(12, 7, 0);
        drain("t2_drain");

        // 3: glitches ignored, long press pauses, second press resumes
        rst   = 1'b0;
        up_dn = 1'b1;
        reset_release("t3");
        expect_stb(4, 1, 0);
        expect_stb(8, 2, 0);
        expect_stb(12, 3, 0);
        btn_run = 1'b1;
        wait_to(1);  btn_run = 1'b0;
        wait_to(2);  btn_run = 1'b1;
        wait_to(4);  btn_run = 1'b0;
        wait_to(6);  btn_run = 1'b1;
        wait_to(12); chk("t3_running_before", int'(running), 1);
        wait_to(13); chk("t3_running_paused", int'(running), 0);
        wait_to(14); btn_run = 1'b0;
        wait_to(20);
        chk("t3_digit_frozen", int'(digit), 3);
        chk("t3_still_paused", int'(running), 0);
        wait_to(22); btn_run = 1'b1;
        expect_stb(32, 4, 0);
        expect_stb(36, 5, 0);
        wait_to(28); chk("t3_running_not_yet", int'(running), 0);
        wait_to(29); chk("t3_running_resumed", int'(running), 1);
        wait_to(30); btn_run = 1'b0;

        // 4: clear mid-prescale at digit 5, then clear held over digit 0
        wait_to(37); clr = 1'b1;
        expect_stb(38, 0, 0);
        expect_stb(42, 1, 0);
        wait_to(38); clr = 1'b0;
        chk("t4_clr_digit", int'(digit), 0);
        wait_to(42); clr = 1'b1;
        expect_stb(43, 0, 0);
        wait_to(44); clr = 1'b0;
        chk("t4_clr_zero_nostb", int'(digit_stb), 0);
        chk("t4_clr_zero_digit", int'(digit), 0);
        expect_stb(48, 1, 0);

        // 5: clear on the tick cycle at digit 9 suppresses carry
        for (int j = 0; j < 8; j++) begin
            expect_stb(52 + 4 * j, 2 + j, 0);
        end
        expect_stb(84, 0, 0);
        expect_stb(88, 1, 0);
        wait_to(83); clr = 1'b1;
        wait_to(84); clr = 1'b0;
        chk("t5_clr_tick_carry", int'(carry), 0);
        chk("t5_clr_tick_stb", int'(digit_stb), 1);
        chk("t5_clr_tick_digit", int'(digit), 0);

        // 6: pause at digit 7, then asynchronous reset between edges
        for (int j = 0; j < 6; j++) begin
            expect_stb(92 + 4 * j, 2 + j, 0);
        end
        wait_to(107); btn_run = 1'b1;
        wait_to(113); chk("t6_running_before", int'(running), 1);
        wait_to(114); chk("t6_running_paused", int'(running), 0);
        wait_to(115); btn_run = 1'b0;
        wait_to(118);
        chk("t6_digit_held", int'(digit), 7);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_digit", int'(digit), 0);
        chk("t6_async_running", int'(running), 1);
        chk("t6_async_stb", int'(digit_stb), 0);
        drain("t6_drain_before");
        reset_release("t6");
        expect_stb(4, 1, 0);
        expect_stb(8, 2, 0);
        drain("t6_drain_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
